// File: rtl/ram_arbiter_if.sv
// Shared RAM arbiter bus: IF fetch port, MEM load/store port, RAM port.
// slave = arbiter side, master = core + RAM side.
interface ram_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [63:0] if_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        ram_ren;
  logic        ram_wen;
  logic [63:0] ram_ridx;
  logic [63:0] ram_widx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;
  logic [63:0] ram_rdata;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_size,
    input  ram_rdata,
    output if_ready, if_rvalid, if_rdata,
    output mem_ready, mem_rvalid, mem_rdata,
    output ram_ren, ram_wen,
    output ram_ridx, ram_widx,
    output ram_wdata, ram_wmask
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_size,
    output ram_rdata,
    input  if_ready, if_rvalid, if_rdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    input  ram_ren, ram_wen,
    input  ram_ridx, ram_widx,
    input  ram_wdata, ram_wmask
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port (IF/MEM) arbiter onto one shared RAM port.
// One transaction in flight: IDLE -> ACCESS -> RESP.
module ram_arbiter #(
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic         clock,
  input logic         reset,
  ram_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  logic [1:0]  state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        src_mem_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] if_rdata_q;
  logic [63:0] mem_rdata_q;

  logic        idle, access, resp;
  logic        grant_if, grant_mem;
  logic        if_rv, mem_rv, mem_ld_rv;
  logic [5:0]  sh;
  logic [63:0] mask_b;
  logic [63:0] idx;

  assign idle   = (state_q == S_IDLE);
  assign access = (state_q == S_ACCESS);
  assign resp   = (state_q == S_RESP);

  // IF only overtakes MEM once it has been starved STARVE_MAX times
  assign grant_if  = idle & bus.if_req &
                     (~bus.mem_req | (starve_q == SMAX));
  assign grant_mem = idle & bus.mem_req & ~grant_if;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      idle:   if (grant_if | grant_mem) state_d = S_ACCESS;
      access: state_d = S_RESP;
      resp:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (grant_mem) begin
      if (!bus.if_req)           starve_d = '0;
      else if (starve_q != SMAX) starve_d = starve_q + 3'd1;
    end
  end

  always_comb begin
    sh     = '0;
    mask_b = '1;
    unique case (size_q)
      2'd0: begin
        sh     = {addr_q[2:0], 3'b000};
        mask_b = 64'hFF;
      end
      2'd1: begin
        sh     = {addr_q[2:1], 4'b0000};
        mask_b = 64'hFFFF;
      end
      2'd2: begin
        sh     = {addr_q[2], 5'b00000};
        mask_b = 64'hFFFF_FFFF;
      end
      default: begin
        sh     = '0;
        mask_b = '1;
      end
    endcase
  end

  assign idx = (addr_q - BASE) >> 3;

  assign bus.ram_ren   = access & ~we_q;
  assign bus.ram_wen   = access & we_q;
  assign bus.ram_ridx  = bus.ram_ren ? idx : '0;
  assign bus.ram_widx  = bus.ram_wen ? idx : '0;
  assign bus.ram_wdata = bus.ram_wen ? (wdata_q << sh) : '0;
  assign bus.ram_wmask = bus.ram_wen ? (mask_b << sh) : '0;

  // Reset wins over a request already sitting on the bus
  assign bus.if_ready  = grant_if & reset;
  assign bus.mem_ready = grant_mem & reset;

  assign if_rv     = resp & ~src_mem_q;
  assign mem_rv    = resp & src_mem_q;
  assign mem_ld_rv = mem_rv & ~we_q;

  assign bus.if_rvalid  = if_rv;
  assign bus.mem_rvalid = mem_rv;
  // RAM data arrives in RESP; forward it, then hold it
  assign bus.if_rdata   = if_rv ? bus.ram_rdata : if_rdata_q;
  assign bus.mem_rdata  = mem_ld_rv ? bus.ram_rdata : mem_rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      src_mem_q   <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (grant_if | grant_mem) begin
        src_mem_q <= grant_mem;
        we_q      <= grant_mem & bus.mem_we;
        size_q    <= grant_mem ? bus.mem_size : 2'd3;
        addr_q    <= grant_mem ? bus.mem_addr : bus.if_addr;
        wdata_q   <= bus.mem_wdata;
      end
      if (if_rv)     if_rdata_q  <= bus.ram_rdata;
      if (mem_ld_rv) mem_rdata_q <= bus.ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a small masked RAM model.
// Expected responses are queued at grant and checked at rvalid.
module tb_ram_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ram_arbiter_if bus();

  ram_arbiter #(
    .BASE(64'h8000_0000),
    .STARVE_MAX(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic        is_mem;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [63:0] exp_mem_rdata = '0;

  logic [63:0] ram [0:15];
  logic [15:0] wr_seen = '0;

  function automatic logic [63:0] init_word(logic [3:0] i);
    if (i == 4'd2) return 64'h1122_3344_5566_7788;
    return 64'hA5A5_0000_0000_0000 | {60'h0, i};
  endfunction

  always @(posedge clock) begin
    if (bus.ram_ren)
      bus.ram_rdata <= wr_seen[bus.ram_ridx[3:0]] ?
        ram[bus.ram_ridx[3:0]] : init_word(bus.ram_ridx[3:0]);
    if (bus.ram_wen) begin
      ram[bus.ram_widx[3:0]] <=
        ((wr_seen[bus.ram_widx[3:0]] ? ram[bus.ram_widx[3:0]]
          : init_word(bus.ram_widx[3:0])) & ~bus.ram_wmask)
        | (bus.ram_wdata & bus.ram_wmask);
      wr_seen[bus.ram_widx[3:0]] <= 1'b1;
    end
  end

  localparam logic [63:0] S_ADDR [4] = '{
    64'h8000_0005, 64'h8000_0003,
    64'h8000_000C, 64'h8000_0027};
  localparam logic [1:0]  S_SIZE [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  localparam logic [63:0] S_WD   [4] = '{
    64'hAB, 64'h1234,
    64'hCAFE_BABE, 64'h0123_4567_89AB_CDEF};
  localparam logic [63:0] S_IDX  [4] = '{64'd0, 64'd0, 64'd1, 64'd4};
  localparam logic [63:0] S_MASK [4] = '{
    64'h0000_FF00_0000_0000, 64'h0000_0000_FFFF_0000,
    64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [63:0] S_SWD  [4] = '{
    64'h0000_AB00_0000_0000, 64'h0000_0000_1234_0000,
    64'hCAFE_BABE_0000_0000, 64'h0123_4567_89AB_CDEF};

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic smp;
    @(negedge clock);
  endtask

  task automatic test_reset;
    bus.if_req = 0; bus.if_addr = '0;
    bus.mem_req = 0; bus.mem_we = 0;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.mem_size = '0;
    reset = 0;
    smp; smp;
    n_cmp++;
    if ({bus.if_ready, bus.mem_ready, bus.if_rvalid,
         bus.mem_rvalid, bus.ram_ren, bus.ram_wen} !== 6'b0) begin
      n_err++;
      $display("FAIL rst_ctl: got %b want 0",
        {bus.if_ready, bus.mem_ready, bus.if_rvalid,
         bus.mem_rvalid, bus.ram_ren, bus.ram_wen});
    end
    n_cmp++;
    if ({bus.if_rdata, bus.mem_rdata} !== 128'h0) begin
      n_err++;
      $display("FAIL rst_rdata: got %h want 0",
        {bus.if_rdata, bus.mem_rdata});
    end
    n_cmp++;
    if ({bus.ram_ridx, bus.ram_widx, bus.ram_wdata,
         bus.ram_wmask} !== 256'h0) begin
      n_err++;
      $display("FAIL rst_ram: got %h want 0",
        {bus.ram_ridx, bus.ram_widx, bus.ram_wdata, bus.ram_wmask});
    end
    @(posedge clock); #1 reset = 1;
    smp;
    n_cmp++;
    if ({bus.if_ready, bus.mem_ready, bus.ram_ren, bus.ram_wen}
        !== 4'b0) begin
      n_err++;
      $display("FAIL idle_ctl: got %b want 0",
        {bus.if_ready, bus.mem_ready, bus.ram_ren, bus.ram_wen});
    end
    cyc;
  endtask

  task automatic test_if_read;
    exp_t e;
    bus.if_req = 1; bus.if_addr = 64'h8000_0010;
    smp;
    n_cmp++;
    if ({bus.if_ready, bus.mem_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL if_ready: got %b want 10",
        {bus.if_ready, bus.mem_ready});
    end
    exp_q.push_back('{1'b0, 64'h1122_3344_5566_7788});
    cyc;
    bus.if_req = 0; bus.if_addr = 64'h8000_0100;
    smp;
    n_cmp++;
    if ({bus.ram_ren, bus.ram_wen, bus.ram_ridx}
        !== {2'b10, 64'd2}) begin
      n_err++;
      $display("FAIL if_access: got %b/%0d want 10/2",
        {bus.ram_ren, bus.ram_wen}, bus.ram_ridx);
    end
    cyc; smp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL if_resp: got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      if ({bus.if_rvalid, bus.mem_rvalid, bus.if_rdata}
          !== {~e.is_mem, e.is_mem, e.data}) begin
        n_err++;
        $display("FAIL if_resp: got %b %h want 10 %h",
          {bus.if_rvalid, bus.mem_rvalid}, bus.if_rdata, e.data);
      end
    end
    n_cmp++;
    if ({bus.ram_ren, bus.ram_wen, bus.ram_ridx} !== 66'h0) begin
      n_err++;
      $display("FAIL resp_ram_idle: got %h want 0",
        {bus.ram_ren, bus.ram_wen, bus.ram_ridx});
    end
    cyc; smp;
    n_cmp++;
    if ({bus.if_rvalid, bus.if_rdata}
        !== {1'b0, 64'h1122_3344_5566_7788}) begin
      n_err++;
      $display("FAIL if_hold: got %b %h want 0 1122334455667788",
        bus.if_rvalid, bus.if_rdata);
    end
    cyc;
  endtask

  task automatic test_stores;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      bus.mem_req = 1; bus.mem_we = 1;
      bus.mem_addr = S_ADDR[i]; bus.mem_size = S_SIZE[i];
      bus.mem_wdata = S_WD[i];
      smp;
      n_cmp++;
      if ({bus.if_ready, bus.mem_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL st%0d_ready: got %b want 01", i,
          {bus.if_ready, bus.mem_ready});
      end
      exp_q.push_back('{1'b1, exp_mem_rdata});
      cyc;
      bus.mem_req = 0;
      smp;
      n_cmp++;
      if ({bus.ram_ren, bus.ram_wen, bus.ram_widx,
           bus.ram_wmask, bus.ram_wdata}
          !== {2'b01, S_IDX[i], S_MASK[i], S_SWD[i]}) begin
        n_err++;
        $display("FAIL st%0d_access: got %b %0d %h %h want 01 %0d %h %h",
          i, {bus.ram_ren, bus.ram_wen}, bus.ram_widx,
          bus.ram_wmask, bus.ram_wdata,
          S_IDX[i], S_MASK[i], S_SWD[i]);
      end
      cyc; smp;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL st%0d_resp: got empty queue want entry", i);
      end else begin
        e = exp_q.pop_front();
        if ({bus.if_rvalid, bus.mem_rvalid, bus.mem_rdata}
            !== {~e.is_mem, e.is_mem, e.data}) begin
          n_err++;
          $display("FAIL st%0d_resp: got %b %h want 01 %h", i,
            {bus.if_rvalid, bus.mem_rvalid}, bus.mem_rdata, e.data);
        end
      end
      cyc;
    end
  endtask

  task automatic test_loads;
    exp_t e;
    logic [63:0] la [2];
    logic [63:0] lv [2];
    la[0] = 64'h8000_0000; lv[0] = 64'hA5A5_AB00_1234_0000;
    la[1] = 64'h8000_0021; lv[1] = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < 2; i++) begin
      bus.mem_req = 1; bus.mem_we = 0;
      bus.mem_addr = la[i]; bus.mem_size = 2'd3;
      smp;
      n_cmp++;
      if (bus.mem_ready !== 1'b1) begin
        n_err++;
        $display("FAIL ld%0d_ready: got %b want 1", i, bus.mem_ready);
      end
      exp_q.push_back('{1'b1, lv[i]});
      exp_mem_rdata = lv[i];
      cyc;
      bus.mem_req = 0;
      cyc; smp;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL ld%0d_resp: got empty queue want entry", i);
      end else begin
        e = exp_q.pop_front();
        if ({bus.mem_rvalid, bus.mem_rdata} !== {1'b1, e.data}) begin
          n_err++;
          $display("FAIL ld%0d_resp: got %b %h want 1 %h", i,
            bus.mem_rvalid, bus.mem_rdata, e.data);
        end
      end
      cyc;
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic m;
    bus.if_req = 1; bus.if_addr = 64'h8000_0010;
    bus.mem_req = 1; bus.mem_we = 0;
    bus.mem_addr = 64'h8000_0008; bus.mem_size = 2'd3;
    for (int g = 0; g < 10; g++) begin
      m = (g % 5) != 4;
      smp;
      n_cmp++;
      if ({bus.if_ready, bus.mem_ready} !== {~m, m}) begin
        n_err++;
        $display("FAIL grant%0d: got %b want %b", g,
          {bus.if_ready, bus.mem_ready}, {~m, m});
      end
      exp_q.push_back('{m, m ? 64'hCAFE_BABE_0000_0001
                             : 64'h1122_3344_5566_7788});
      cyc; smp;
      n_cmp++;
      if ({bus.ram_ren, bus.if_ready, bus.mem_ready} !== 3'b100) begin
        n_err++;
        $display("FAIL b2b%0d_access: got %b want 100", g,
          {bus.ram_ren, bus.if_ready, bus.mem_ready});
      end
      cyc; smp;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL b2b%0d_resp: got empty queue want entry", g);
      end else begin
        e = exp_q.pop_front();
        if ({bus.if_rvalid, bus.mem_rvalid,
             e.is_mem ? bus.mem_rdata : bus.if_rdata}
            !== {~e.is_mem, e.is_mem, e.data}) begin
          n_err++;
          $display("FAIL b2b%0d_resp: got %b %h/%h want %b %h", g,
            {bus.if_rvalid, bus.mem_rvalid}, bus.if_rdata,
            bus.mem_rdata, {~e.is_mem, e.is_mem}, e.data);
        end
      end
      cyc;
    end
    bus.if_req = 0; bus.mem_req = 0;
    exp_mem_rdata = 64'hCAFE_BABE_0000_0001;
    cyc;
  endtask

  task automatic test_change_during_access;
    exp_t e;
    bus.mem_req = 1; bus.mem_we = 1;
    bus.mem_addr = 64'h8000_0030; bus.mem_size = 2'd3;
    bus.mem_wdata = 64'h0F0E_0D0C_0B0A_0908;
    smp;
    exp_q.push_back('{1'b1, exp_mem_rdata});
    n_cmp++;
    if (bus.mem_ready !== 1'b1) begin
      n_err++;
      $display("FAIL chg_ready: got %b want 1", bus.mem_ready);
    end
    cyc;
    bus.mem_addr = 64'h8000_0040; bus.mem_we = 0;
    bus.mem_size = 2'd0; bus.mem_wdata = '1;
    smp;
    n_cmp++;
    if ({bus.ram_wen, bus.ram_ren, bus.ram_widx,
         bus.ram_wmask, bus.ram_wdata}
        !== {2'b10, 64'd6, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h0F0E_0D0C_0B0A_0908}) begin
      n_err++;
      $display("FAIL chg_access: got %b %0d %h %h want 10 6 ones 0f0e0d0c0b0a0908",
        {bus.ram_wen, bus.ram_ren}, bus.ram_widx,
        bus.ram_wmask, bus.ram_wdata);
    end
    bus.mem_req = 0;
    cyc; smp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL chg_resp: got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      if ({bus.mem_rvalid, bus.mem_rdata} !== {1'b1, e.data}) begin
        n_err++;
        $display("FAIL chg_resp: got %b %h want 1 %h",
          bus.mem_rvalid, bus.mem_rdata, e.data);
      end
    end
    cyc;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bus.if_req = 1; bus.if_addr = 64'h8000_0010;
    smp;
    n_cmp++;
    if (bus.if_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rm_ready: got %b want 1", bus.if_ready);
    end
    cyc; smp;
    n_cmp++;
    if (bus.ram_ren !== 1'b1) begin
      n_err++;
      $display("FAIL rm_access: got %b want 1", bus.ram_ren);
    end
    #1 reset = 0;
    #1;
    n_cmp++;
    if ({bus.ram_ren, bus.ram_ridx, bus.if_rdata, bus.mem_rdata}
        !== 193'h0) begin
      n_err++;
      $display("FAIL rm_drop: got ren=%b idx=%0d rd=%h/%h want 0",
        bus.ram_ren, bus.ram_ridx, bus.if_rdata, bus.mem_rdata);
    end
    @(posedge clock); smp;
    n_cmp++;
    if ({bus.if_rvalid, bus.if_ready} !== 2'b00) begin
      n_err++;
      $display("FAIL rm_in_reset: got %b want 00",
        {bus.if_rvalid, bus.if_ready});
    end
    @(posedge clock); #1 reset = 1;
    smp;
    n_cmp++;
    if ({bus.if_ready, bus.if_rvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL rm_first_edge: got %b want 10",
        {bus.if_ready, bus.if_rvalid});
    end
    exp_q.push_back('{1'b0, 64'h1122_3344_5566_7788});
    cyc;
    bus.if_req = 0;
    cyc; smp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL rm_resp: got empty queue want entry");
    end else begin
      e = exp_q.pop_front();
      if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, e.data}) begin
        n_err++;
        $display("FAIL rm_resp: got %b %h want 1 %h",
          bus.if_rvalid, bus.if_rdata, e.data);
      end
    end
    cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_if_read;
    test_stores;
    test_loads;
    test_back_to_back;
    test_change_during_access;
    test_reset_mid;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end
endmodule
